// File: rtl/pulse_monitor_if.sv
// Pulse monitor bus: the pulse input and enable going in, measurement results coming out.
interface pulse_monitor_if #(
  parameter int WIDTH = 8
);
  logic             signal;
  logic             enable;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic [WIDTH-1:0] edge_count;

  modport master (
    output signal,
    output enable,
    input  period,
    input  high_time,
    input  valid,
    input  timeout,
    input  edge_count
  );

  modport slave (
    input  signal,
    input  enable,
    output period,
    output high_time,
    output valid,
    output timeout,
    output edge_count
  );
endinterface

// File: rtl/pulse_monitor.sv
// Measures period and high time of an asynchronous pulse train, with timeout and edge counting.
// Duty measurement (hcnt/high_time) is compiled in only when PULSE_MONITOR_DUTY_EN is defined.
module pulse_monitor #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 200
) (
  input logic            clock,
  input logic            reset_n,
  pulse_monitor_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] STALL   = 2'd2;

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [1:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] edge_count_q;
  logic             valid_q;
  logic             timeout_q;
  logic             in_measure;
  logic             restart;
  logic             meas_done;
  logic             stall_hit;
  logic             step;
  logic             bad_state;

  function automatic logic [WIDTH-1:0] inc(input logic [WIDTH-1:0] v, input logic b);
    return v + {{(WIDTH-1){1'b0}}, b};
  endfunction

  // Synchronizer stage: s1/s2 resynchronize, s3 is history for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.signal;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise       = s2 & ~s3;
  assign in_measure = (state == MEASURE);
  assign restart    = bus.enable & rise;
  assign meas_done  = restart & in_measure;
  assign stall_hit  = bus.enable & ~rise & in_measure & (cnt == CNT_LAST);
  assign step       = bus.enable & ~rise & in_measure & (cnt != CNT_LAST);
  assign bad_state  = (state != IDLE) && (state != MEASURE) && (state != STALL);

  // Measurement stage: FSM, period counter, timeout and edge counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      edge_count_q <= '0;
    end else if (!bus.enable) begin
      state     <= IDLE;
      cnt       <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= meas_done;
      if (restart) begin
        state        <= MEASURE;
        cnt          <= '0;
        timeout_q    <= 1'b0;
        edge_count_q <= inc(edge_count_q, 1'b1);
      end else if (stall_hit) begin
        state     <= STALL;
        timeout_q <= 1'b1;
      end else if (step) begin
        cnt <= inc(cnt, 1'b1);
      end else if (bad_state) begin
        state <= IDLE;
        cnt   <= '0;
      end
      // cnt is capped at TIMEOUT-1, so cnt+1 always fits in WIDTH bits
      if (meas_done) begin
        period_q <= inc(cnt, 1'b1);
      end
    end
  end

  assign bus.period     = period_q;
  assign bus.valid      = valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.edge_count = edge_count_q;

`ifdef PULSE_MONITOR_DUTY_EN
  logic [WIDTH-1:0] hcnt;
  logic [WIDTH-1:0] high_q;

  // Duty stage: hcnt starts at 1 because s2 is already high in the rise cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcnt   <= '0;
      high_q <= '0;
    end else if (!bus.enable) begin
      hcnt <= '0;
    end else begin
      if (restart) begin
        hcnt <= CNT_ONE;
      end else if (step) begin
        hcnt <= inc(hcnt, s2);
      end
      if (meas_done) begin
        high_q <= hcnt;
      end
    end
  end

  assign bus.high_time = high_q;
`else
  assign bus.high_time = '0;
`endif

endmodule

// File: tb/tb_pulse_monitor.sv
// Randomized scoreboard bench for pulse_monitor against a window-based reference model.
module tb_pulse_monitor;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 200;
  localparam int MAXE    = 40000;

  logic clock;
  logic reset_n;
  logic sig_d;
  logic en_d;

  pulse_monitor_if #(.WIDTH(WIDTH)) bus ();

  assign bus.signal = sig_d;
  assign bus.enable = en_d;

  pulse_monitor #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int edge_n;
    int per;
    int hi;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  bit hist [0:MAXE-1];
  int cur_edge = 0;
  int base     = 0;
  bit armed    = 0;
  int last     = 0;
  int m_ec     = 0;
  bit m_tmo    = 0;
  int m_per    = 0;
  int m_hi     = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cur_edge, act, exp);
    end
  endtask

  function automatic bit h(input int i);
    if (i < base || i < 0 || i >= MAXE) return 1'b0;
    return hist[i];
  endfunction

  // Model: a rise is a 0->1 step in the input samples, acted on two edges later.
  // A valid measurement spans consecutive enabled rises no more than TIMEOUT edges apart.
  always @(posedge clock) begin
    int e;
    bit rise;
    int s;
    cur_edge++;
    e = cur_edge;
    if (!reset_n) begin
      base  = e + 1;
      armed = 0;
      m_tmo = 0;
      m_ec  = 0;
      m_per = 0;
      m_hi  = 0;
      sb.delete();
    end else begin
      if (e < MAXE) hist[e] = sig_d;
      rise = h(e - 2) && !h(e - 3);
      if (!en_d) begin
        armed = 0;
        m_tmo = 0;
      end else if (rise) begin
        m_ec = (m_ec + 1) % (1 << WIDTH);
        if (armed) begin
          s = 0;
          for (int m = last; m < e; m++) s += h(m - 2);
`ifdef PULSE_MONITOR_DUTY_EN
          m_hi = s;
`else
          m_hi = 0;
`endif
          m_per = e - last;
          sb.push_back('{edge_n: e, per: m_per, hi: m_hi});
        end
        armed = 1;
        last  = e;
        m_tmo = 0;
      end else if (armed && (e - last) == TIMEOUT) begin
        armed = 0;
        m_tmo = 1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes valid
  always @(negedge clock) begin
    bit exp_v;
    exp_t x;
    if (reset_n) begin
      while (sb.size() > 0 && sb[0].edge_n < cur_edge) begin
        x = sb.pop_front();
        check("valid_missing", 0, x.edge_n);
      end
      exp_v = (sb.size() > 0 && sb[0].edge_n == cur_edge);
      check("valid", int'(bus.valid), int'(exp_v));
      if (exp_v) begin
        x = sb.pop_front();
        check("period_at_valid", int'(bus.period), x.per);
        check("high_at_valid", int'(bus.high_time), x.hi);
      end
      check("period_hold", int'(bus.period), m_per);
      check("high_hold", int'(bus.high_time), m_hi);
      check("edge_count", int'(bus.edge_count), m_ec);
      check("timeout", int'(bus.timeout), int'(m_tmo));
    end
  end

  task automatic cyc(input bit s, input bit en);
    @(negedge clock);
    sig_d = s;
    en_d  = en;
  endtask

  task automatic pulses(input int n, input int per, input int hi);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < per; i++) cyc(i < hi, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, int'(bus.period), 0);
    check({tag, "_high"}, int'(bus.high_time), 0);
    check({tag, "_valid"}, int'(bus.valid), 0);
    check({tag, "_timeout"}, int'(bus.timeout), 0);
    check({tag, "_edge_count"}, int'(bus.edge_count), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_zero("async_reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int per;
    int hi;
    reset_n = 1'b0;
    sig_d   = 1'b0;
    en_d    = 1'b0;
    repeat (3) @(negedge clock);
    check_zero("reset_state");
    reset_n = 1'b1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);

    // divide-by-3 train: 6-clock period, 3 high
    pulses(10, 6, 3);

    // random periods and duty cycles
    for (int k = 0; k < 30; k++) begin
      per = $urandom_range(2, 40);
      hi  = $urandom_range(1, per - 1);
      pulses(1, per, hi);
    end

    // reset mid-period discards the partial measurement
    pulses(3, 6, 3);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    pulse_reset();
    pulses(5, 6, 3);

    // timeout after one rise, then recovery
    pulses(1, 6, 3);
    for (int i = 0; i < 210; i++) cyc(1'b0, 1'b1);
    pulses(4, 6, 3);

    // boundary: window of exactly TIMEOUT is measured, TIMEOUT+1 times out
    pulses(1, TIMEOUT, 1);
    pulses(1, TIMEOUT + 1, 1);
    pulses(3, 6, 3);

    // enable dropped for two cycles mid-period
    pulses(2, 6, 3);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    pulses(4, 6, 3);

    // edge_count wrap: more than 256 rises
    pulses(260, 2, 1);
    pulses(3, 6, 3);

    // random enable dropouts over random pulse trains
    for (int k = 0; k < 40; k++) begin
      per = $urandom_range(2, 20);
      hi  = $urandom_range(1, per - 1);
      for (int i = 0; i < per; i++) cyc(i < hi, $urandom_range(0, 15) != 0);
    end
    pulses(3, 6, 3);
    repeat (4) cyc(1'b0, 1'b1);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the width of the counters and measurement outputs.
REQ-002 The block SHALL have parameter TIMEOUT, default 200, giving the maximum legal period in clocks; legal range 2..2^WIDTH-1.
REQ-003 Port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port signal  input  1  pulse train from the upstream divider; asynchronous to clock.
REQ-006 Port enable  input  1  measurement enable.
REQ-007 Port period  output  WIDTH  clocks between the last two rising edges of signal.
REQ-008 Port high_time  output  WIDTH  clocks signal was high within the measured period.
REQ-009 Port valid  output  1  one-cycle strobe; period/high_time updated.
REQ-010 Port timeout  output  1  no rising edge within TIMEOUT clocks; sticky.
REQ-011 Port edge_count  output  WIDTH  count of rising edges seen while enabled, modulo 2^WIDTH.

Function
REQ-012 signal SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 AND NOT s3.
REQ-013 Latency: signal first sampled high at edge k SHALL give rise at edge k+1 and registered outputs/valid at edge k+2.
REQ-014 The FSM SHALL have states IDLE, MEASURE and STALL.
REQ-015 IDLE: on rise the FSM SHALL go to MEASURE, clear cnt to 0, set hcnt to 1, and SHALL NOT assert valid.
REQ-016 MEASURE, each edge without rise: cnt += 1; hcnt += s2.
REQ-017 MEASURE with rise: period <= cnt+1, high_time <= hcnt, valid <= 1 for exactly one cycle, cnt <= 0, hcnt <= 1.
REQ-018 MEASURE without rise when cnt+1 == TIMEOUT: the FSM SHALL go to STALL with timeout <= 1; period and high_time hold.
REQ-019 STALL: counting stops; on rise the FSM SHALL go to MEASURE with cnt <= 0, hcnt <= 1, timeout <= 0, and no valid.
REQ-020 edge_count SHALL increment on every rise while enable=1 in any state, wrapping from 2^WIDTH-1 to 0.
REQ-021 If enable=0 at an edge: FSM <= IDLE, cnt/hcnt <= 0, valid <= 0, timeout <= 0; period, high_time and edge_count hold; synchronizer keeps running.
REQ-022 valid SHALL be 0 in every cycle not immediately following a REQ-017 update.
REQ-023 cnt SHALL never exceed TIMEOUT-1, so period needs no saturation.

Reset
REQ-024 reset_n=0 SHALL immediately, without a clock, force FSM=IDLE, and s1, s2, s3, cnt, hcnt, period, high_time, valid, timeout and edge_count all to 0.
REQ-025 After reset_n rises, the first rise SHALL produce no valid; reset mid-period SHALL discard the partial measurement.

Configuration
REQ-026 Macro PULSE_MONITOR_DUTY_EN: when defined, hcnt and the high_time updates are compiled in per REQ-015..REQ-019.
REQ-027 Without PULSE_MONITOR_DUTY_EN, no hcnt logic SHALL exist and high_time SHALL be constant 0; all other behaviour is unchanged.

Verification
REQ-028 Divide-by-3 toggling input (6-clock period, 3 high), enable=1, macro on -> first rise gives no valid; each later rise gives valid=1 for 1 cycle with period=6, high_time=3; edge_count increments by 1 per rise.
REQ-029 Reset pulsed low mid-period -> all outputs 0 asynchronously; next rise gives no valid; the rise after that gives period=6.
REQ-030 After one rise, signal held low -> timeout=1 at the edge where cnt+1=200, state STALL; next rise clears timeout with no valid; following rise gives valid with the correct period.
REQ-031 256 rises with WIDTH=8 -> edge_count returns to 0; period and valid unaffected.
REQ-032 enable dropped for 2 cycles mid-period -> no valid for that period; first rise after re-enable gives no valid; the next gives period=6.
REQ-033 Macro off, 6-clock input -> period=6, high_time=0 at every valid.
